// File: rtl/fifo_sync_ext.sv
// Single-clock circular-buffer FIFO with fill level, almost-full/empty thresholds,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module fifo_sync_ext #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 256,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4,
   parameter int FWFT      = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write_en,
   input  logic                       read_en,
   input  logic [WIDTH-1:0]           data_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             overflow_reg;
   logic             underflow_reg;
   logic             rd_ok;
   logic             wr_ok;

   // A read frees the slot in the same cycle, so a full FIFO can still take a write.
   assign rd_ok = read_en && (count_reg != '0);
   assign wr_ok = write_en && ((count_reg != CW'(DEPTH)) || rd_ok);

   always_ff @(posedge clk) begin
      if (wr_ok && !reset) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (wr_ok && !rd_ok) begin
            count_reg <= count_reg + 1'b1;
         end else if (rd_ok && !wr_ok) begin
            count_reg <= count_reg - 1'b1;
         end
         overflow_reg  <= write_en && !wr_ok;
         underflow_reg <= read_en && !rd_ok;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is visible combinationally; forced to zero while nothing is stored.
         assign data_out = (count_reg == '0) ? '0 : mem[rd_ptr_reg];
      end else begin : g_std
         logic [WIDTH-1:0] data_out_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               data_out_reg <= '0;
            end else if (rd_ok) begin
               data_out_reg <= mem[rd_ptr_reg];
            end
         end
         assign data_out = data_out_reg;
      end
   endgenerate

   assign count        = count_reg;
   assign empty        = (count_reg == '0);
   assign full         = (count_reg == CW'(DEPTH));
   assign almost_full  = (count_reg >= CW'(AF_THRESH));
   assign almost_empty = (count_reg <= CW'(AE_THRESH));
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_sync_ext.sv
// Scoreboard bench for fifo_sync_ext: three instances (256x8 standard, 16x8 FWFT,
// 4x32 standard) exercised one at a time against a queue model.
module tb_fifo_sync_ext;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we_t = 1'b0;
   logic        re_t = 1'b0;
   logic [31:0] din_t = '0;
   int          sel = 0;

   always #5 clk = ~clk;

   typedef struct {
      int          cnt;
      bit          ovf;
      bit          unf;
      bit          dchk;
      logic [31:0] dexp;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mq[$];
   logic [31:0] dout_m;
   int          total = 0;
   int          bad = 0;

   // instance 0: 256x8 standard
   logic [7:0]  dout0;
   logic [8:0]  cnt0;
   logic        f0, e0, af0, ae0, ov0, un0;
   fifo_sync_ext #(.WIDTH(8), .DEPTH(256), .AF_THRESH(252), .AE_THRESH(4), .FWFT(0)) u0 (
      .clk(clk), .reset(reset), .write_en(we_t && sel == 0), .read_en(re_t && sel == 0),
      .data_in(din_t[7:0]), .data_out(dout0), .full(f0), .empty(e0), .almost_full(af0),
      .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0));

   // instance 1: 16x8 FWFT
   logic [7:0]  dout1;
   logic [4:0]  cnt1;
   logic        f1, e1, af1, ae1, ov1, un1;
   fifo_sync_ext #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u1 (
      .clk(clk), .reset(reset), .write_en(we_t && sel == 1), .read_en(re_t && sel == 1),
      .data_in(din_t[7:0]), .data_out(dout1), .full(f1), .empty(e1), .almost_full(af1),
      .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1));

   // instance 2: 4x32 standard
   logic [31:0] dout2;
   logic [2:0]  cnt2;
   logic        f2, e2, af2, ae2, ov2, un2;
   fifo_sync_ext #(.WIDTH(32), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u2 (
      .clk(clk), .reset(reset), .write_en(we_t && sel == 2), .read_en(re_t && sel == 2),
      .data_in(din_t), .data_out(dout2), .full(f2), .empty(e2), .almost_full(af2),
      .almost_empty(ae2), .count(cnt2), .overflow(ov2), .underflow(un2));

   function automatic int depth_p();
      return (sel == 0) ? 256 : (sel == 1) ? 16 : 4;
   endfunction
   function automatic int af_p();
      return (sel == 0) ? 252 : (sel == 1) ? 12 : 3;
   endfunction
   function automatic int ae_p();
      return (sel == 0) ? 4 : (sel == 1) ? 4 : 1;
   endfunction
   function automatic logic [31:0] mask_p();
      return (sel == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s sel=%0d t=%0t actual=%h required=%h", name, sel, $time, act, exp);
      end
   endtask

   // Monitor: one expected record per clock edge, checked 1 time unit after the edge.
   initial begin : monitor
      exp_t        e;
      logic [31:0] a_d;
      int          a_c;
      logic        a_f, a_e, a_af, a_ae, a_ov, a_un;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            case (sel)
               0: begin a_d = {24'h0, dout0}; a_c = int'(cnt0); a_f = f0; a_e = e0;
                        a_af = af0; a_ae = ae0; a_ov = ov0; a_un = un0; end
               1: begin a_d = {24'h0, dout1}; a_c = int'(cnt1); a_f = f1; a_e = e1;
                        a_af = af1; a_ae = ae1; a_ov = ov1; a_un = un1; end
               default: begin a_d = dout2; a_c = int'(cnt2); a_f = f2; a_e = e2;
                        a_af = af2; a_ae = ae2; a_ov = ov2; a_un = un2; end
            endcase
            chk("count", a_c, e.cnt);
            chk("empty", {31'h0, a_e}, {31'h0, e.cnt == 0});
            chk("full", {31'h0, a_f}, {31'h0, e.cnt == depth_p()});
            chk("almost_full", {31'h0, a_af}, {31'h0, e.cnt >= af_p()});
            chk("almost_empty", {31'h0, a_ae}, {31'h0, e.cnt <= ae_p()});
            chk("overflow", {31'h0, a_ov}, {31'h0, e.ovf});
            chk("underflow", {31'h0, a_un}, {31'h0, e.unf});
            if (e.dchk) chk("data_out", a_d, e.dexp);
         end
      end
   end

   // Drive one cycle of stimulus and push the model's post-edge expectation.
   task automatic step(input bit we, input bit re, input logic [31:0] din);
      exp_t e;
      int   sz;
      bit   rd, wr;
      @(negedge clk);
      reset = 1'b0;
      we_t  = we;
      re_t  = re;
      din_t = din;
      sz    = mq.size();
      rd    = re && (sz > 0);
      wr    = we && ((sz < depth_p()) || rd);
      e.ovf = we && !wr;
      e.unf = re && !rd;
      if (rd) dout_m = mq.pop_front();
      if (wr) mq.push_back(din & mask_p());
      e.cnt = mq.size();
      if (sel == 1) begin
         e.dchk = (mq.size() > 0);
         e.dexp = (mq.size() > 0) ? mq[0] : '0;
      end else begin
         e.dchk = 1'b1;
         e.dexp = dout_m;
      end
      sb.push_back(e);
   endtask

   task automatic do_reset(input int which, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sel   = which;
         reset = 1'b1;
         we_t  = 1'b1;
         re_t  = 1'b1;
         din_t = 32'hDEAD_BEEF;
         mq.delete();
         dout_m = '0;
         e.cnt = 0; e.ovf = 0; e.unf = 0; e.dchk = 1; e.dexp = '0;
         sb.push_back(e);
      end
   endtask

   task automatic random_mix(input int n, input int pw, input int pr);
      for (int i = 0; i < n; i++) begin
         step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, $urandom());
      end
   endtask

   initial begin
      // 256x8 standard instance
      do_reset(0, 2);
      step(1, 0, 32'h57);
      do_reset(0, 1);
      step(0, 0, 0);
      for (int i = 0; i < 256; i++) step(1, 0, i);
      step(1, 0, 32'h99);
      step(0, 0, 0);
      for (int i = 0; i < 256; i++) step(0, 1, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      for (int i = 0; i < 256; i++) step(1, 0, i);
      step(1, 1, 32'hAA);
      for (int i = 0; i < 256; i++) step(0, 1, 0);
      step(0, 0, 0);
      step(1, 1, 32'h33);
      step(0, 1, 0);
      for (int i = 0; i < 10; i++) step(1, 0, i);
      for (int i = 0; i < 600; i++) step(1, 1, 10 + i);
      for (int i = 0; i < 10; i++) step(0, 1, 0);
      random_mix(2000, 70, 40);
      random_mix(2000, 40, 70);

      // 16x8 FWFT instance
      do_reset(1, 2);
      step(1, 0, 32'h11);
      step(1, 0, 32'h22);
      step(0, 0, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      random_mix(3000, 55, 50);

      // 4x32 standard instance
      do_reset(2, 2);
      random_mix(10000, 50, 50);

      step(0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_sync_ext.md
# fifo_sync_ext

Parametrised next-generation synchronous FIFO: single-clock circular buffer with configurable width and depth, a fill-level output, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It replaces the basic `fifo_sync` in datapaths that need back-pressure ahead of the hard full/empty limits or zero-latency head-of-queue visibility.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 256: number of storage entries. Must be a power of two, ≥2.
- `AF_THRESH`, DEPTH-4: `almost_full` asserts when count ≥ AF_THRESH. Range 1..DEPTH.
- `AE_THRESH`, 4: `almost_empty` asserts when count ≤ AE_THRESH. Range 0..DEPTH-1.
- `FWFT`, 0: 0 selects standard registered-read mode; 1 selects first-word-fall-through mode.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `write_en` in 1: write request for the current cycle.
- `read_en` in 1: read (pop) request for the current cycle.
- `data_in` in WIDTH: write data, sampled when a write is accepted.
- `data_out` out WIDTH: read data. The mode determines when it is valid (see Operation).
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AF_THRESH.
- `almost_empty` out 1: count ≤ AE_THRESH.
- `count` out $clog2(DEPTH+1): current number of stored words, 0..DEPTH.
- `overflow` out 1: one-cycle pulse, a write was rejected.
- `underflow` out 1: one-cycle pulse, a read was rejected.

## Operation
- Storage: DEPTH×WIDTH array. `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. `count` is a separate register.
- Accept rules, evaluated on the current cycle's registered state:
  - `rd_ok` = read_en && !empty.
  - `wr_ok` = write_en && (!full || rd_ok). A write while full is accepted when a read is accepted in the same cycle.
- On an accepted write: mem[wr_ptr] ← data_in, then wr_ptr+1.
- On an accepted read: rd_ptr+1.
- Count update: count +1 on a write only, −1 on a read only, unchanged when both or neither occur.
- Rejected requests:
  - `overflow` pulses on the next edge when write_en && !wr_ok.
  - `underflow` pulses on the next edge when read_en && !rd_ok.
  - A rejected request changes no pointer, count, memory or data_out.
- Empty with simultaneous write and read: the write is accepted, the read is rejected (underflow pulses), and count becomes 1.
- Standard mode (FWFT=0): data_out is registered. On an accepted read, data_out ← mem[rd_ptr]. It holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] continuously whenever !empty, and read_en acknowledges and pops the head word. data_out is don't-care while empty; the bench must not check it then.
- All flags (`full`, `empty`, `almost_*`) are decoded from the registered count, so they are glitch-free and valid right after each edge.
- Reset:
  - count=0, wr_ptr=rd_ptr=0, data_out=0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH≥1).
  - overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored words on that edge and takes priority over same-cycle write_en/read_en.

## Timing
- Write-to-flag latency is 1 cycle: the edge that accepts a write updates count and the flags.
- Standard-mode read latency is 1 cycle: data_out is valid after the edge that accepts the read and is sampled at #1 after the edge.
- FWFT mode:
  - The first word written into an empty FIFO appears on data_out after the write edge (1 cycle); no read is needed.
  - After a pop edge, the next word is presented immediately.
- Full throughput is one write and one read per cycle, sustained, at any count including 0 (write only) and DEPTH (read+write).
- overflow and underflow are high for exactly the one cycle following the offending request edge.

## Test plan
- Reset/flags:
  - Assert reset for 2 cycles, then release → count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, overflow=underflow=0.
  - Write 0x57 → count=1.
  - Assert reset for 1 cycle → count=0, empty=1.
- Ordering and thresholds (DEPTH=256, AE=4, AF=252):
  - Write 0..255 → almost_empty drops when count=5, almost_full rises when count=252, full when count=256.
  - A 257th write → overflow pulses for 1 cycle, count stays 256.
  - Drain → data_out reads 0x00..0xFF in order, empty at the end.
  - An extra read → underflow pulses, data_out holds 0xFF.
- Simultaneous events:
  - At full, apply write 0xAA + read in the same cycle → count stays 256, no overflow. After draining, 0xAA is the last word out.
  - At empty, apply write 0x33 + read → count=1, underflow pulses, and the next read returns 0x33.
- Pointer wrap: with count held at 10, perform 600 cycles of simultaneous read/write using an incrementing pattern → output sequence is contiguous with no skips or duplicates, count remains 10.
- FWFT=1 instance:
  - Write 0x11, 0x22 → data_out=0x11 one cycle after the first write, with no read.
  - Pop → data_out=0x22.
  - Pop → empty=1.
- Randomized mix against a queue model for 10k cycles → every data_out, count and flag value matches the model. Rerun with DEPTH=4 and WIDTH=32.
